// File: rtl/nco_phase_acc_if.sv
// nco_phase_acc_if: feedback input stream and phase output stream of the NCO.
interface nco_phase_acc_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] feedback_tdata;
  logic                    feedback_tvalid;
  logic [WIDTH-1:0]        phase_tdata;
  logic                    phase_tvalid;
  logic                    phase_tready;
  modport master (
    input  feedback_tdata, feedback_tvalid, phase_tready,
    output phase_tdata, phase_tvalid
  );
  modport slave (
    output feedback_tdata, feedback_tvalid, phase_tready,
    input  phase_tdata, phase_tvalid
  );
endinterface

// File: rtl/nco_phase_acc.sv
// nco_phase_acc: two-gear NCO phase accumulator with valid/ready phase output.
// Define NCO_FREQ_SAT_EN to clamp the frequency word to [0, Nyquist] instead of wrapping.
module nco_phase_acc #(
  parameter int WIDTH = 16,
  parameter int ACC_WIDTH = 24,
  parameter logic [ACC_WIDTH-1:0] FREE_FREQ = ACC_WIDTH'(1) << (ACC_WIDTH - 2),
  parameter int ACQ_COUNT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 relock,
  input  logic [3:0]           ACQ_SHIFT,
  input  logic [3:0]           TRACK_SHIFT,
  input  logic [WIDTH-1:0]     phase_offset,
  output logic [ACC_WIDTH-1:0] freq_tdata,
  output logic [1:0]           state,
  nco_phase_acc_if.master      bus
);
  localparam int CW = $clog2(ACQ_COUNT + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, ACQUIRE = 2'b01, TRACK = 2'b10} state_t;
  state_t                      st;
  logic [ACC_WIDTH-1:0]        acc;
  logic signed [ACC_WIDTH-1:0] corr;
  logic signed [ACC_WIDTH-1:0] fb_ext;
  logic signed [ACC_WIDTH-1:0] corr_next;
  logic [CW-1:0]               cnt;
  logic                        adv;
  logic                        cap;
  logic                        do_relock;
  logic                        acq_done;
  assign state     = st;
  assign fb_ext    = ACC_WIDTH'(bus.feedback_tdata);
  assign corr_next = fb_ext >>> (st == ACQUIRE ? ACQ_SHIFT : TRACK_SHIFT);
  assign adv       = enable && (!bus.phase_tvalid || bus.phase_tready);
  assign do_relock = relock && (st != IDLE || enable);
  assign cap       = enable && bus.feedback_tvalid && st != IDLE && !do_relock;
  assign acq_done  = cnt + CW'(1) == CW'(ACQ_COUNT);
`ifdef NCO_FREQ_SAT_EN
  logic signed [ACC_WIDTH:0] sum;
  assign sum = $signed({1'b0, FREE_FREQ}) + $signed({corr[ACC_WIDTH-1], corr});
  assign freq_tdata = sum[ACC_WIDTH] ? '0 :
                      sum[ACC_WIDTH-1] ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : sum[ACC_WIDTH-1:0];
`else
  assign freq_tdata = FREE_FREQ + $unsigned(corr);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      acc              <= '0;
      corr             <= '0;
      cnt              <= '0;
      st               <= IDLE;
      bus.phase_tdata  <= '0;
      bus.phase_tvalid <= 1'b0;
    end else begin
      if (adv) begin
        bus.phase_tdata  <= acc[ACC_WIDTH-1 -: WIDTH] + phase_offset;
        bus.phase_tvalid <= 1'b1;
        acc              <= acc + freq_tdata;
      end else if (!enable && bus.phase_tready) begin
        bus.phase_tvalid <= 1'b0;
      end
      if (do_relock) begin
        st   <= ACQUIRE;
        cnt  <= '0;
        corr <= '0;
      end else if (enable) begin
        if (st == IDLE) begin
          st  <= ACQUIRE;
          cnt <= '0;
        end
        if (cap) corr <= corr_next;
        // Only ACQUIRE captures count towards the gear change.
        if (cap && st == ACQUIRE) begin
          cnt <= cnt + CW'(1);
          if (acq_done) st <= TRACK;
        end
      end
    end
  end
endmodule

// File: tb/tb_nco_phase_acc.sv
// tb_nco_phase_acc: directed vectors for nco_phase_acc with hand-computed phases.
module tb_nco_phase_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        relock = 1'b0;
  logic [3:0]  acq_shift = 4'd0;
  logic [3:0]  track_shift = 4'd4;
  logic [15:0] phase_offset = 16'h0000;
  logic [23:0] freq, s_freq;
  logic [1:0]  st, s_st;
  int          n_checks = 0;
  int          n_fail = 0;
  nco_phase_acc_if #(.WIDTH(16)) m_if ();
  nco_phase_acc_if #(.WIDTH(16)) s_if ();
  nco_phase_acc #(.WIDTH(16), .ACC_WIDTH(24), .FREE_FREQ(24'h400000), .ACQ_COUNT(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .relock(relock),
    .ACQ_SHIFT(acq_shift), .TRACK_SHIFT(track_shift), .phase_offset(phase_offset),
    .freq_tdata(freq), .state(st), .bus(m_if.master)
  );
  nco_phase_acc #(.WIDTH(16), .ACC_WIDTH(24), .FREE_FREQ(24'h000100), .ACQ_COUNT(4)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .relock(relock),
    .ACQ_SHIFT(acq_shift), .TRACK_SHIFT(track_shift), .phase_offset(phase_offset),
    .freq_tdata(s_freq), .state(s_st), .bus(s_if.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] free_run [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
    m_if.feedback_tdata = '0;
    m_if.feedback_tvalid = 1'b0;
    m_if.phase_tready = 1'b1;
    s_if.feedback_tdata = 16'sh8000;
    s_if.feedback_tvalid = 1'b1;
    s_if.phase_tready = 1'b1;
    step();
    step();
    check("rst_tvalid", 32'(m_if.phase_tvalid), 32'd0);
    check("rst_tdata", 32'(m_if.phase_tdata), 32'h0);
    check("rst_state", 32'(st), 32'd0);
    check("rst_freq", 32'(freq), 32'h400000);
    check("rst_sat_freq", 32'(s_freq), 32'h000100);
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("free_%0d", i), 32'(m_if.phase_tdata), 32'(free_run[i]));
      check($sformatf("free_v%0d", i), 32'(m_if.phase_tvalid), 32'd1);
    end
    check("free_state", 32'(st), 32'd1);
    check("free_freq", 32'(freq), 32'h400000);
    step();
    check("bp_pre", 32'(m_if.phase_tdata), 32'h4000);
    m_if.phase_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold_%0d", i), 32'(m_if.phase_tdata), 32'h4000);
      check($sformatf("bp_valid_%0d", i), 32'(m_if.phase_tvalid), 32'd1);
    end
    m_if.phase_tready = 1'b1;
    step();
    check("bp_next", 32'(m_if.phase_tdata), 32'h8000);
    m_if.feedback_tdata = 16'sh0100;
    m_if.feedback_tvalid = 1'b1;
    step();
    check("gear_ph1", 32'(m_if.phase_tdata), 32'hC000);
    check("gear_freq_acq", 32'(freq), 32'h400100);
    step();
    check("gear_ph2", 32'(m_if.phase_tdata), 32'h0000);
    step();
    check("gear_ph3", 32'(m_if.phase_tdata), 32'h4001);
    check("gear_state_acq", 32'(st), 32'd1);
    step();
    check("gear_state_trk", 32'(st), 32'd2);
    check("gear_freq_4th", 32'(freq), 32'h400100);
    step();
    check("gear_freq_trk", 32'(freq), 32'h400010);
    check("gear_ph5", 32'(m_if.phase_tdata), 32'hC003);
    relock = 1'b1;
    m_if.feedback_tdata = 16'sh7FFF;
    step();
    relock = 1'b0;
    m_if.feedback_tvalid = 1'b0;
    check("relock_state", 32'(st), 32'd1);
    check("relock_freq", 32'(freq), 32'h400000);
    check("relock_ph1", 32'(m_if.phase_tdata), 32'h0004);
    step();
    check("relock_ph2", 32'(m_if.phase_tdata), 32'h4004);
    check("relock_freq2", 32'(freq), 32'h400000);
    enable = 1'b0;
    m_if.phase_tready = 1'b0;
    step();
    check("dis_hold_v", 32'(m_if.phase_tvalid), 32'd1);
    check("dis_hold_d", 32'(m_if.phase_tdata), 32'h4004);
    m_if.phase_tready = 1'b1;
    step();
    check("dis_drain", 32'(m_if.phase_tvalid), 32'd0);
    check("dis_state", 32'(st), 32'd1);
    enable = 1'b1;
    m_if.phase_tready = 1'b0;
    step();
    check("mid_pend", 32'(m_if.phase_tdata), 32'h8004);
    rst = 1'b1;
    step();
    check("mid_rst_v", 32'(m_if.phase_tvalid), 32'd0);
    check("mid_rst_d", 32'(m_if.phase_tdata), 32'h0);
    check("mid_rst_st", 32'(st), 32'd0);
    rst = 1'b0;
    phase_offset = 16'h1234;
    m_if.phase_tready = 1'b1;
    step();
    check("post_rst_ph", 32'(m_if.phase_tdata), 32'h1234);
    check("post_rst_v", 32'(m_if.phase_tvalid), 32'd1);
    check("post_rst_st", 32'(st), 32'd1);
    step();
    check("post_rst_ph2", 32'(m_if.phase_tdata), 32'h5234);
`ifdef NCO_FREQ_SAT_EN
    check("sat_freq", 32'(s_freq), 32'h000000);
`else
    check("sat_freq", 32'(s_freq), 32'hFF8100);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nco_phase_acc.md
# nco_phase_acc

Parametrised NCO phase generator for the Costas-loop carrier path. It turns signed loop-filter feedback into a frequency word with two-gear gain (acquire/track). It accumulates that word into a wrapping phase and adds a static phase offset. The resulting phase is delivered to the DDS over a valid/ready stream with backpressure.

## Interface
- WIDTH, 16: feedback and output phase width.
- ACC_WIDTH, 24: accumulator and frequency-word width; must be ≥ WIDTH.
- FREE_FREQ, 2^(ACC_WIDTH-2): unsigned free-running frequency word (fs/4).
- ACQ_COUNT, 1024: accepted feedback samples spent in ACQUIRE; ≥ 1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  allows generation of new phase samples and feedback capture.
- relock  in  1  single-cycle pulse; restarts acquisition.
- ACQ_SHIFT  in  4  arithmetic right shift of feedback in ACQUIRE.
- TRACK_SHIFT  in  4  arithmetic right shift of feedback in TRACK.
- phase_offset  in  WIDTH  added to the output phase, mod 2^WIDTH.
- feedback_tdata  in  WIDTH signed  loop-filter output.
- feedback_tvalid  in  1  feedback qualifier; there is no ready signal.
- phase_tdata  out  WIDTH  phase to DDS.
- phase_tvalid  out  1  output valid.
- phase_tready  in  1  DDS accepts the current sample.
- freq_tdata  out  ACC_WIDTH  current frequency word, for debug.
- state  out  2  00 IDLE, 01 ACQUIRE, 10 TRACK.

## Operation
- **Registers:** acc (ACC_WIDTH), corr (ACC_WIDTH signed), cnt (ceil(log2(ACQ_COUNT+1))), state, phase_tdata, phase_tvalid.
- **Correction capture:** when `enable && feedback_tvalid` and state ≠ IDLE:
  - corr <= sign_extend(feedback_tdata, ACC_WIDTH) >>> shift.
  - shift is ACQ_SHIFT in ACQUIRE and TRACK_SHIFT in TRACK.
  - Without a valid feedback sample, corr holds its last value.
- **Frequency word:** freq = FREE_FREQ + corr, computed combinationally from registered corr and driven on freq_tdata.
- **Advance condition:** `enable && (!phase_tvalid || phase_tready)`. On advance:
  - phase_tdata <= acc[ACC_WIDTH-1 -: WIDTH] + phase_offset (mod 2^WIDTH).
  - acc <= acc + freq (mod 2^ACC_WIDTH).
  - phase_tvalid <= 1.
- **No advance, tvalid high, tready low:** phase_tdata and phase_tvalid are held.
- **enable low:** a pending sample stays valid until accepted, then phase_tvalid <= 0. acc, corr, cnt and state are frozen.
- **State machine:**
  - IDLE -> ACQUIRE on the first cycle with enable high; cnt <= 0.
  - In ACQUIRE, each captured feedback sample increments cnt. The capture that makes cnt reach ACQ_COUNT moves state to TRACK on that edge.
  - TRACK is held until relock or rst.
- **relock** (priority below rst): state <= ACQUIRE, cnt <= 0, corr <= 0. acc and the output stream are untouched, so phase stays continuous. Feedback presented in the same cycle is discarded. relock in IDLE with enable low is ignored.

## Timing
- **Reset values:** acc = 0, corr = 0, cnt = 0, state = IDLE, phase_tdata = 0, phase_tvalid = 0, freq_tdata = FREE_FREQ.
- **First output:** the first advance after reset presents phase_offset, i.e. accumulator phase 0.
- **Feedback latency:** feedback captured at edge k updates corr at edge k. It first affects the acc increment of the advance at edge k+1. It first appears in phase_tdata at the advance after that.
- **Throughput:** one sample per clock with tready held high.
- **ACQUIRE → TRACK:** TRACK_SHIFT applies from the capture following the transition edge.
- **Reset mid-stream:** rst overrides all other inputs; phase_tvalid drops on that edge even if a sample is pending.

## Configuration
- **NCO_FREQ_SAT_EN defined:** FREE_FREQ + corr is computed at ACC_WIDTH+1 bits signed and clamped to [0, 2^(ACC_WIDTH-1)-1] (DC to Nyquist) before use and before driving freq_tdata.
- **NCO_FREQ_SAT_EN undefined:** the sum wraps mod 2^ACC_WIDTH.

## Test plan
All scenarios use WIDTH = 16, ACC_WIDTH = 24, FREE_FREQ = 0x400000, ACQ_COUNT = 4.
- **Free run:** rst, then enable = 1, tready = 1, offset = 0, no feedback -> phase_tdata 0x0000, 0x4000, 0x8000, 0xC000, 0x0000; state 01; freq_tdata 0x400000.
- **Backpressure:** tready low for 3 cycles at sample 0x4000 -> phase_tdata 0x4000 and tvalid = 1 stable for 3 cycles; acc does not advance; next sample after tready is 0x8000.
- **Gear shift:** ACQ_SHIFT = 0, TRACK_SHIFT = 4, feedback 0x0100 valid every cycle -> freq 0x400100 during ACQUIRE; state 10 after the 4th capture; freq 0x400010 from the 5th capture.
- **Relock:** relock pulse together with feedback 0x7FFF while in TRACK -> state 01, corr = 0, freq 0x400000; phase sequence continues without a jump.
- **Saturation:** feedback 0x8000, ACQ_SHIFT = 0 (corr = 0xFF8000 signed) with FREE_FREQ = 0x000100:
  - NCO_FREQ_SAT_EN defined -> freq_tdata 0x000000.
  - NCO_FREQ_SAT_EN undefined -> freq_tdata 0xFF8100.
- **Reset mid-operation:** rst asserted while tvalid = 1 and tready = 0 -> next cycle tvalid = 0, phase_tdata = 0, state = 00; with enable high, the first output after release is phase_offset.
